sme_multi: RTL and testbench

SME_MULTI -- requirements
Module: sme_multi

---
 rtl/sme_pkg.sv | 22 ++
 rtl/sme_char_cmp.sv | 39 +++
 rtl/sme_multi.sv | 235 +++++++++++++++++++++++
 tb/tb_sme_multi.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sme_pkg.sv
// Shared constants, default sizes and FSM state type for the string match engine.
package sme_pkg;

    localparam int CW_DEF      = 8;
    localparam int STR_MAX_DEF = 32;
    localparam int PAT_MAX_DEF = 8;

    localparam logic [7:0] CHR_SPACE  = 8'h20;
    localparam logic [7:0] CHR_CARET  = 8'h5E;
    localparam logic [7:0] CHR_DOLLAR = 8'h24;
    localparam logic [7:0] CHR_DOT    = 8'h2E;
    localparam logic [7:0] CHR_STAR   = 8'h2A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_STR,
        ST_LOAD_PAT,
        ST_SEARCH,
        ST_REPORT
    } state_e;

endpackage

// File: rtl/sme_char_cmp.sv
// Single pattern token against the string character at the current position,
// including the word-boundary tests for the zero-width anchors.
module sme_char_cmp
    import sme_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic [CW-1:0] tok,
    input  logic [CW-1:0] chr,
    input  logic [CW-1:0] prev_chr,
    input  logic          at_start,
    input  logic          at_end,
    output logic          is_star,
    output logic          is_zero,
    output logic          ok
);

    // Classify the token and decide whether it is satisfied at this position.
    always_comb begin
        is_star = 1'b0;
        is_zero = 1'b0;
        ok      = 1'b0;
        if (tok == CW'(CHR_STAR)) begin
            is_star = 1'b1;
            ok      = 1'b1;
        end else if (tok == CW'(CHR_CARET)) begin
            is_zero = 1'b1;
            ok      = at_start || (prev_chr == CW'(CHR_SPACE));
        end else if (tok == CW'(CHR_DOLLAR)) begin
            is_zero = 1'b1;
            ok      = at_end || (chr == CW'(CHR_SPACE));
        end else if (tok == CW'(CHR_DOT)) begin
            ok = !at_end;
        end else begin
            ok = !at_end && (chr == tok);
        end
    end

endmodule

// File: rtl/sme_multi.sv
// String match engine: loads a string and a pattern in bursts, then searches
// one comparison or backtrack step per cycle and reports leftmost or all matches.
module sme_multi
    import sme_pkg::*;
#(
    parameter int CW      = CW_DEF,
    parameter int STR_MAX = STR_MAX_DEF,
    parameter int PAT_MAX = PAT_MAX_DEF,
    parameter int IDXW    = $clog2(STR_MAX + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CW-1:0]   chardata,
    input  logic            isstring,
    input  logic            ispattern,
    input  logic            find_all,
    output logic            match,
    output logic [IDXW-1:0] match_index,
    output logic [IDXW-1:0] match_len,
    output logic            valid,
    output logic            last,
    output logic            busy,
    output logic            overflow
);

    localparam int PW = $clog2(PAT_MAX + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   str_mem_q [0:STR_MAX];
    logic [CW-1:0]   str_mem_d [0:STR_MAX];
    logic [CW-1:0]   pat_mem_q [0:PAT_MAX];
    logic [CW-1:0]   pat_mem_d [0:PAT_MAX];
    logic [IDXW-1:0] str_len_q, str_len_d;
    logic [PW-1:0]   pat_len_q, pat_len_d;
    logic            str_ovf_q, str_ovf_d;
    logic            pat_ovf_q, pat_ovf_d;
    logic            find_all_q, find_all_d;
    logic [IDXW-1:0] s_q, s_d, i_q, i_d, star_i_q, star_i_d;
    logic [PW-1:0]   j_q, j_d, star_j_q, star_j_d;
    logic            star_v_q, star_v_d;
    logic            exhausted_q, exhausted_d;
    logic            match_q, match_d, last_q, last_d;
    logic [IDXW-1:0] idx_q, idx_d, len_q, len_d;

    logic            pat_en;
    logic [IDXW-1:0] prev_idx;
    logic            cmp_star, cmp_zero, cmp_ok;

    // A pattern character that arrives together with a string character is dropped.
    assign pat_en   = ispattern & ~isstring;
    assign prev_idx = (i_q == '0) ? '0 : i_q - 1'b1;

    sme_char_cmp #(.CW(CW)) u_cmp (
        .tok      (pat_mem_q[j_q]),
        .chr      (str_mem_q[i_q]),
        .prev_chr (str_mem_q[prev_idx]),
        .at_start (i_q == '0),
        .at_end   (i_q == str_len_q),
        .is_star  (cmp_star),
        .is_zero  (cmp_zero),
        .ok       (cmp_ok)
    );

    // Burst loading; each burst kind keeps its own sticky overflow bit so a
    // pattern load does not hide that the string was truncated.
    always_comb begin
        str_mem_d  = str_mem_q;
        pat_mem_d  = pat_mem_q;
        str_len_d  = str_len_q;
        pat_len_d  = pat_len_q;
        str_ovf_d  = str_ovf_q;
        pat_ovf_d  = pat_ovf_q;
        find_all_d = find_all_q;
        if (isstring) begin
            if (state_q != ST_LOAD_STR) begin
                str_mem_d[0] = chardata;
                str_len_d    = IDXW'(1);
                str_ovf_d    = 1'b0;
            end else if (str_len_q < IDXW'(STR_MAX)) begin
                str_mem_d[str_len_q] = chardata;
                str_len_d            = str_len_q + 1'b1;
            end else begin
                str_ovf_d = 1'b1;
            end
        end else if (pat_en) begin
            if (state_q != ST_LOAD_PAT) begin
                pat_mem_d[0] = chardata;
                pat_len_d    = PW'(1);
                pat_ovf_d    = 1'b0;
                find_all_d   = find_all;
            end else if (pat_len_q < PW'(PAT_MAX)) begin
                pat_mem_d[pat_len_q] = chardata;
                pat_len_d            = pat_len_q + 1'b1;
            end else begin
                pat_ovf_d = 1'b1;
            end
        end
    end

    // Next state and search step: a new burst always wins and aborts any search.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        i_d         = i_q;
        j_d         = j_q;
        star_i_d    = star_i_q;
        star_j_d    = star_j_q;
        star_v_d    = star_v_q;
        exhausted_d = exhausted_q;
        match_d     = match_q;
        last_d      = last_q;
        idx_d       = idx_q;
        len_d       = len_q;
        if (isstring) begin
            state_d = ST_LOAD_STR;
        end else if (pat_en) begin
            state_d = ST_LOAD_PAT;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_LOAD_STR: state_d = ST_IDLE;
                ST_LOAD_PAT: begin
                    state_d     = ST_SEARCH;
                    s_d         = '0;
                    i_d         = '0;
                    j_d         = '0;
                    star_v_d    = 1'b0;
                    exhausted_d = 1'b0;
                end
                ST_SEARCH: begin
                    if (exhausted_q) begin
                        match_d = 1'b0;
                        last_d  = 1'b1;
                        state_d = ST_REPORT;
                    end else if (j_q == pat_len_q) begin
                        match_d  = 1'b1;
                        idx_d    = s_q;
                        len_d    = i_q - s_q;
                        last_d   = ~find_all_q;
                        state_d  = ST_REPORT;
                        star_v_d = 1'b0;
                        j_d      = '0;
                        if (s_q == str_len_q) begin
                            exhausted_d = 1'b1;
                        end else begin
                            s_d = s_q + 1'b1;
                            i_d = s_q + 1'b1;
                        end
                    end else if (cmp_star) begin
                        star_v_d = 1'b1;
                        star_j_d = j_q;
                        star_i_d = i_q;
                        j_d      = j_q + 1'b1;
                    end else if (cmp_ok) begin
                        j_d = j_q + 1'b1;
                        if (!cmp_zero) begin
                            i_d = i_q + 1'b1;
                        end
                    end else if (star_v_q && (star_i_q != str_len_q)) begin
                        star_i_d = star_i_q + 1'b1;
                        i_d      = star_i_q + 1'b1;
                        j_d      = star_j_q + 1'b1;
                    end else if (s_q == str_len_q) begin
                        match_d = 1'b0;
                        last_d  = 1'b1;
                        state_d = ST_REPORT;
                    end else begin
                        s_d      = s_q + 1'b1;
                        i_d      = s_q + 1'b1;
                        j_d      = '0;
                        star_v_d = 1'b0;
                    end
                end
                ST_REPORT: state_d = last_q ? ST_IDLE : ST_SEARCH;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            str_len_q   <= '0;
            pat_len_q   <= '0;
            str_ovf_q   <= 1'b0;
            pat_ovf_q   <= 1'b0;
            find_all_q  <= 1'b0;
            s_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            star_i_q    <= '0;
            star_j_q    <= '0;
            star_v_q    <= 1'b0;
            exhausted_q <= 1'b0;
            match_q     <= 1'b0;
            last_q      <= 1'b0;
            idx_q       <= '0;
            len_q       <= '0;
        end else begin
            state_q     <= state_d;
            str_len_q   <= str_len_d;
            pat_len_q   <= pat_len_d;
            str_ovf_q   <= str_ovf_d;
            pat_ovf_q   <= pat_ovf_d;
            find_all_q  <= find_all_d;
            s_q         <= s_d;
            i_q         <= i_d;
            j_q         <= j_d;
            star_i_q    <= star_i_d;
            star_j_q    <= star_j_d;
            star_v_q    <= star_v_d;
            exhausted_q <= exhausted_d;
            match_q     <= match_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
        end
    end

    // Character storage; contents beyond the stored lengths are never read.
    always_ff @(posedge clk) begin
        str_mem_q <= str_mem_d;
        pat_mem_q <= pat_mem_d;
    end

    assign valid       = (state_q == ST_REPORT);
    assign last        = last_q & valid;
    assign busy        = (state_q == ST_SEARCH) || (state_q == ST_REPORT);
    assign overflow    = str_ovf_q | pat_ovf_q;
    assign match       = match_q;
    assign match_index = idx_q;
    assign match_len   = len_q;

endmodule

// File: tb/tb_sme_multi.sv
// Self-checking bench for sme_multi: directed cases plus random strings and
// patterns checked against a queue-based reference matcher.
module tb_sme_multi;

    localparam int CW      = 8;
    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;
    localparam int IDXW    = $clog2(STR_MAX + 1);
    localparam int BOUND   = (STR_MAX + 2) * (PAT_MAX + 1);

    typedef byte byte_q_t[$];
    typedef struct {
        bit is_match;
        int idx;
        int len;
        bit is_last;
    } result_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [CW-1:0]   chardata;
    logic            isstring;
    logic            ispattern;
    logic            find_all;
    logic            match;
    logic [IDXW-1:0] match_index;
    logic [IDXW-1:0] match_len;
    logic            valid;
    logic            last;
    logic            busy;
    logic            overflow;

    int      n_compared   = 0;
    int      n_mismatched = 0;
    string   cur_test     = "reset";
    byte_q_t model_str;
    byte_q_t model_pat;
    bit      model_str_ovf = 1'b0;
    bit      model_pat_ovf = 1'b0;
    result_t exp_q[$];
    byte     s_alpha[4] = '{"a", "b", " ", "c"};
    byte     p_alpha[7] = '{"a", "b", ".", "*", "^", "$", " "};

    sme_multi #(.CW(CW), .STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX)) dut (
        .clk         (clk),
        .reset       (reset),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .find_all    (find_all),
        .match       (match),
        .match_index (match_index),
        .match_len   (match_len),
        .valid       (valid),
        .last        (last),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #(1_000_000);
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_compared++;
        if (got !== expv) begin
            n_mismatched++;
            $display("[TB] FAIL %s.%s: got %0d, expected %0d", cur_test, tag, got, expv);
        end
    endtask

    function automatic byte_q_t toBytes(input string s);
        byte_q_t q;
        for (int k = 0; k < s.len(); k++) q.push_back(s[k]);
        return q;
    endfunction

    // Length consumed when the pattern is anchored at string position start, or -1.
    function automatic int refMatchLen(input byte_q_t str, input byte_q_t pat, input int start);
        int pos = start;
        int tok = 0;
        int star_tok = -1;
        int star_end = 0;
        bit hit;
        while (1) begin
            if (tok == pat.size()) return pos - start;
            if (pat[tok] == "*") begin
                star_tok = tok;
                star_end = pos;
                tok++;
            end else begin
                if (pat[tok] == "^")
                    hit = (pos == 0) || (str[pos-1] == " ");
                else if (pat[tok] == "$")
                    hit = (pos == str.size()) || (str[pos] == " ");
                else if (pat[tok] == ".")
                    hit = (pos < str.size());
                else
                    hit = (pos < str.size()) && (str[pos] == pat[tok]);
                if (hit) begin
                    if (pat[tok] != "^" && pat[tok] != "$") pos++;
                    tok++;
                end else if (star_tok >= 0 && star_end < str.size()) begin
                    star_end++;
                    pos = star_end;
                    tok = star_tok + 1;
                end else begin
                    return -1;
                end
            end
        end
    endfunction

    task automatic buildExpected(input bit fa);
        int l;
        exp_q.delete();
        for (int s = 0; s <= model_str.size(); s++) begin
            l = refMatchLen(model_str, model_pat, s);
            if (l >= 0) begin
                exp_q.push_back('{1'b1, s, l, !fa});
                if (!fa) return;
            end
        end
        exp_q.push_back('{1'b0, 0, 0, 1'b1});
    endtask

    task automatic loadBursts(input byte_q_t s, input bit send_str, input byte_q_t p, input bit fa);
        if (send_str) begin
            model_str.delete();
            for (int k = 0; k < s.size(); k++) begin
                @(negedge clk);
                isstring  = 1'b1;
                ispattern = 1'b0;
                chardata  = s[k];
                if (k < STR_MAX) model_str.push_back(s[k]);
            end
            model_str_ovf = (s.size() > STR_MAX);
        end
        model_pat.delete();
        for (int k = 0; k < p.size(); k++) begin
            @(negedge clk);
            isstring  = 1'b0;
            ispattern = 1'b1;
            find_all  = (k == 0) ? fa : !fa;
            chardata  = p[k];
            if (k < PAT_MAX) model_pat.push_back(p[k]);
        end
        model_pat_ovf = (p.size() > PAT_MAX);
        @(negedge clk);
        isstring  = 1'b0;
        ispattern = 1'b0;
    endtask

    task automatic collectResults();
        int waited = 0;
        int got = 0;
        bit done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (valid) begin
                if (got < exp_q.size()) begin
                    checkOutput("match", match, exp_q[got].is_match);
                    checkOutput("last", last, exp_q[got].is_last);
                    if (exp_q[got].is_match) begin
                        checkOutput("index", match_index, exp_q[got].idx);
                        checkOutput("len", match_len, exp_q[got].len);
                    end
                end
                got++;
                waited = 0;
                if (last || got > exp_q.size()) done = 1'b1;
            end else begin
                waited++;
                if (waited > BOUND) begin
                    checkOutput("result_wait", valid, 1'b1);
                    done = 1'b1;
                end
            end
        end
        checkOutput("n_results", got, exp_q.size());
    endtask

    task automatic applyStimulus(input string name, input byte_q_t s, input bit send_str,
                                 input byte_q_t p, input bit fa);
        cur_test = name;
        loadBursts(s, send_str, p, fa);
        buildExpected(fa);
        @(negedge clk);
        checkOutput("busy", busy, 1'b1);
        checkOutput("overflow", overflow, model_str_ovf | model_pat_ovf);
        collectResults();
    endtask

    task automatic checkAllZero();
        checkOutput("z_match", match, 0);
        checkOutput("z_index", match_index, 0);
        checkOutput("z_len", match_len, 0);
        checkOutput("z_valid", valid, 0);
        checkOutput("z_last", last, 0);
        checkOutput("z_busy", busy, 0);
        checkOutput("z_overflow", overflow, 0);
    endtask

    initial begin
        byte_q_t rs;
        byte_q_t rp;
        int      n_valid;
        reset     = 1'b1;
        isstring  = 1'b0;
        ispattern = 1'b0;
        chardata  = '0;
        find_all  = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero();
        reset = 1'b0;

        applyStimulus("abcab_single", toBytes("abcab"), 1, toBytes("ab"), 0);
        applyStimulus("abcab_all", toBytes(""), 0, toBytes("ab"), 1);
        applyStimulus("anchor", toBytes("xx ab"), 1, toBytes("^a.$"), 0);
        applyStimulus("anchor_star", toBytes(""), 0, toBytes("a*d"), 0);
        applyStimulus("star_span", toBytes("acbd"), 1, toBytes("a*d"), 0);
        applyStimulus("star_tail", toBytes(""), 0, toBytes("b*"), 0);

        rs.delete();
        for (int k = 0; k < STR_MAX + 3; k++) rs.push_back(byte'(8'h61 + (k % 3)));
        applyStimulus("overflow", rs, 1, toBytes("."), 0);

        // A string strobe mid-search aborts it without any result.
        cur_test = "abort";
        loadBursts(toBytes(""), 0, toBytes("zz"), 0);
        @(negedge clk);
        checkOutput("busy", busy, 1'b1);
        @(negedge clk);
        isstring = 1'b1;
        chardata = "q";
        @(negedge clk);
        isstring = 1'b0;
        checkOutput("busy_drop", busy, 1'b0);
        model_str.delete();
        model_str.push_back("q");
        model_str_ovf = 1'b0;
        n_valid = 0;
        if (valid) n_valid++;
        repeat (BOUND) begin
            @(negedge clk);
            if (valid) n_valid++;
        end
        checkOutput("no_valid", n_valid, 0);

        // Reset during the third search cycle clears everything next cycle.
        cur_test = "reset_mid";
        loadBursts(toBytes("abcdefgh"), 1, toBytes("zz"), 0);
        @(negedge clk);
        checkOutput("busy", busy, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkAllZero();
        reset = 1'b0;
        model_str.delete();
        model_str_ovf = 1'b0;
        model_pat_ovf = 1'b0;

        applyStimulus("empty_zz", toBytes(""), 0, toBytes("zz"), 0);
        applyStimulus("empty_star", toBytes(""), 0, toBytes("*"), 0);

        for (int t = 0; t < 40; t++) begin
            rs.delete();
            rp.delete();
            for (int k = 0; k < $urandom_range(1, 10); k++) rs.push_back(s_alpha[$urandom_range(0, 3)]);
            for (int k = 0; k < $urandom_range(1, 4); k++) rp.push_back(p_alpha[$urandom_range(0, 6)]);
            applyStimulus($sformatf("rand%0d", t), rs, 1, rp, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
